hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage RV32I pipeline.
- Decodes the ID-stage instruction's source-register usage with the same opcode map used by immediate generation (inst[6:2]).
- Detects load-use hazards and sequences multi-cycle mul/div ops held in EX.
- Drives all PC/IF_ID/ID_EX stall, flush and bubble controls, and keeps stall/flush performance counters.

Parameters:
- MD_LAT, 4, EX-stage latency in cycles of mul/div ops; legal range 1..16.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- id_inst  input  32  instruction currently in IF/ID.
- ex_rd  input  5  destination register of the EX instruction.
- ex_is_load  input  1  EX instruction is LOAD.
- ex_md_valid  input  1  EX instruction is a mul/div op.
- ex_redirect  input  1  EX resolved a taken branch, JAL or JALR.
- pc_stall  output  1  hold PC.
- if_id_stall  output  1  hold IF/ID register.
- if_id_flush  output  1  load NOP into IF/ID.
- id_ex_stall  output  1  hold ID/EX register.
- id_ex_flush  output  1  load bubble into ID/EX.
- ex_mem_bubble  output  1  load bubble into EX/MEM.
- md_start  output  1  one-cycle start pulse to the mul/div unit.
- md_busy  output  1  mul/div sequence in progress.
- stall_cnt  output  CNT_W  cycles with pc_stall=1.
- flush_cnt  output  CNT_W  accepted redirects.

Behaviour:
- Source usage is decoded from id_inst[6:2].
  - rs1 is used for OP, OP_IMM, LOAD, STORE, BRANCH and JALR.
  - rs2 is used for OP, STORE and BRANCH.
  - LUI, AUIPC, JAL and unknown opcodes use neither.
  - A register index of 0 never causes a hazard.
- load_use = ex_is_load & (ex_rd != 0) & ((use_rs1 & rs1 == ex_rd) | (use_rs2 & rs2 == ex_rd)).
- FSM states are RUN and MD_BUSY. There is a 4-bit down-counter md_cnt.
- RUN, when ex_md_valid=1 and MD_LAT>1 (cycle 0):
  - Assert md_start=1 and md_busy=1.
  - Assert pc_stall, if_id_stall, id_ex_stall and ex_mem_bubble.
  - Load md_cnt=MD_LAT-2 and go to MD_BUSY.
- RUN, when ex_md_valid=1 and MD_LAT=1:
  - Assert md_start=1 only. There is no stall and no state change.
- MD_BUSY:
  - If md_cnt != 0: keep the same four stall/bubble outputs, md_busy=1, md_start=0, and decrement md_cnt.
  - If md_cnt == 0: assert md_busy=1 but no stalls, so the op advances this cycle. Return to RUN.
  - Total stalled cycles for one op = MD_LAT-1. The op leaves EX on cycle MD_LAT-1.
- While in MD_BUSY, ex_md_valid is ignored (no retrigger), and both load_use and ex_redirect are ignored.
- In RUN, priority is md start > ex_redirect > load_use.
- ex_redirect (in RUN, no md start):
  - Assert if_id_flush=1 and id_ex_flush=1 for that cycle. PC is not stalled.
  - Increment flush_cnt.
- load_use (in RUN, no redirect, no md start):
  - Assert pc_stall=1, if_id_stall=1 and id_ex_flush=1 for exactly that cycle.
  - Next cycle the load is in MEM and the hazard clears naturally.
- All outputs not named in the case above are 0.
- Stall/flush outputs are combinational from state and inputs. md_cnt, the state and both counters are registered.
- stall_cnt increments on every cycle with pc_stall=1. Both counters wrap at 2^CNT_W.
- rst=1, including mid-sequence:
  - Next edge: state=RUN, md_cnt=0, stall_cnt=0, flush_cnt=0.
  - During any cycle with rst=1, every stall/flush/bubble/md output is forced to 0.

Test Plan:
1. Load-use: ex_is_load=1, ex_rd=5, id_inst=add x1,x5,x2 (0x002280B3).
   - Required: pc_stall=1, if_id_stall=1, id_ex_flush=1 for one cycle; stall_cnt 0->1.
   - Same stimulus with ex_rd=0 or with id_inst=lui x5 (0x000052B7): all outputs 0.
2. Store rs2 hazard: id_inst=sw x7,0(x3) (0x0071A023) with ex_is_load=1, ex_rd=7.
   - Required: stall asserted.
   - With ex_is_load=0: no stall.
3. Mul/div with MD_LAT=4: pulse ex_md_valid in RUN.
   - Required: md_start=1 in cycle 0 only; stalls plus ex_mem_bubble in cycles 0-2; md_busy in cycles 0-3; RUN in cycle 4; stall_cnt=3.
   - Repeat with MD_LAT=1: md_start only, no stall.
4. Redirect vs load-use: ex_redirect=1 together with a load_use condition.
   - Required: if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt=1.
5. Redirect during MD_BUSY: assert ex_redirect in cycle 1 of a mul/div sequence.
   - Required: ignored; flush_cnt unchanged; sequence still completes in cycle 3.
6. Reset mid-sequence: assert rst in cycle 1 of MD_BUSY.
   - Required: outputs 0 during rst; after release, state=RUN and counters=0.
   - A fresh ex_md_valid restarts with md_start=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage RV32I pipeline.
// Detects load-use hazards on the ID-stage instruction, sequences multi-cycle
// mul/div ops held in EX, and drives PC / IF_ID / ID_EX stall, flush and
// bubble controls. Also keeps stall and redirect performance counters.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   id_inst        instruction in IF/ID
//   ex_rd          EX destination register
//   ex_is_load     EX instruction is a LOAD
//   ex_md_valid    EX instruction is a mul/div op
//   ex_redirect    EX resolved a taken branch / JAL / JALR
//   pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
//   ex_mem_bubble  pipeline controls (combinational from state and inputs)
//   md_start       one-cycle start pulse to the mul/div unit
//   md_busy        mul/div sequence in progress
//   stall_cnt      cycles with pc_stall=1
//   flush_cnt      accepted redirects
module hazard_ctrl #(
  parameter int unsigned MD_LAT = 4,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_md_valid,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned CNT_BITS = 4;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;

  typedef enum logic {RUN, MD_BUSY} state_t;

  state_t              state, state_nxt;
  logic [CNT_BITS-1:0] md_cnt, md_cnt_nxt;
  logic                use_rs1, use_rs2, load_use, flush_acc;
  logic [4:0]          rs1, rs2;

  // Only opcode and register fields matter here; the rest is deliberately dropped.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7], id_inst[1:0]};

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

  // Source-register usage from the major opcode.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_inst[6:2])
      OPC_OP:     begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_STORE:  begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM: use_rs1 = 1'b1;
      OPC_LOAD:   use_rs1 = 1'b1;
      OPC_JALR:   use_rs1 = 1'b1;
      default:    ;
    endcase
  end

  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));

  // Next state and pipeline controls; everything is held at 0 during reset.
  always_comb begin
    state_nxt     = state;
    md_cnt_nxt    = md_cnt;
    flush_acc     = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;
    md_busy       = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (ex_md_valid) begin
            md_start = 1'b1;
            if (MD_LAT > 1) begin
              md_busy       = 1'b1;
              pc_stall      = 1'b1;
              if_id_stall   = 1'b1;
              id_ex_stall   = 1'b1;
              ex_mem_bubble = 1'b1;
              md_cnt_nxt    = CNT_BITS'(MD_LAT - 2);
              state_nxt     = MD_BUSY;
            end
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            flush_acc   = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          // Redirects, load-use and new mul/div requests are ignored here.
          md_busy = 1'b1;
          if (md_cnt != '0) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            md_cnt_nxt    = md_cnt - CNT_BITS'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // State, sequence counter and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (pc_stall)  stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_acc) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
